mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 89 ++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared width defaults and FSM state encoding for the memory responder.
package mem_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, PTR, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, one read or write per enabled cycle.
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  // Callers only enable in-range addresses, so the low bits suffice as index.
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr[AW-1:0]] <= wdata;
      else rdata <= mem[addr[AW-1:0]];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: request/response memory front end with direct and indirect addressing.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_ind,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_eaddr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  state_t state;
  logic we_r, ind_r, ptr_err, use_q, eff_ok, m_en, m_we;
  logic [ADDR_W-1:0] addr_r, eff, m_addr;
  logic [DATA_W-1:0] wdata_r, hold, q, m_wdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < $unsigned(DEPTH);
  endfunction

  // Pointer word arrives from the RAM during ACCESS, so the effective address is combinational there.
  assign eff       = !ind_r ? addr_r : ptr_err ? '0 : q[ADDR_W-1:0];
  assign eff_ok    = in_range(eff);
  assign req_ready = state == IDLE && !ld_en && !reset;
  assign m_en      = !reset && (state == IDLE ? ld_en && in_range(ld_addr) :
                                state == PTR ? in_range(addr_r) : state == ACCESS && eff_ok);
  assign m_we      = state == IDLE || (state == ACCESS && we_r);
  assign m_addr    = state == IDLE ? ld_addr : state == PTR ? addr_r : eff;
  assign m_wdata   = state == IDLE ? ld_data : wdata_r;
  // Load data stays in the RAM output register, which is untouched until the next read.
  assign rsp_rdata = use_q ? q : hold;

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .en(m_en), .we(m_we), .addr(m_addr), .wdata(m_wdata), .rdata(q)
  );

  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_eaddr <= '0;
      rsp_err   <= 1'b0;
      hold      <= '0;
      use_q     <= 1'b0;
      ptr_err   <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            we_r    <= req_we;
            ind_r   <= req_ind;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            ptr_err <= 1'b0;
            state   <= req_ind ? PTR : ACCESS;
          end
        PTR: begin
          ptr_err <= !in_range(addr_r);
          state   <= ACCESS;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_eaddr <= eff;
          rsp_err   <= ptr_err || !eff_ok;
          hold      <= we_r && eff_ok ? wdata_r : '0;
          use_q     <= !we_r && eff_ok;
          state     <= RESP;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
      endcase
endmodule
